select_position_gen: RTL and testbench

- Writer side of the select-RAM window interface.
- Scans one 256-sample detector frame and finds up to three contiguous above-threshold windows.
- Drives start_position_1..3, end_position_1..3, position_3_error_sig and a one-cycle position_gen_en pulse into the select-RAM group, which writes its masks and starts readback.

---
 rtl/select_position_gen.sv | 242 ++++++++++++++++++++++++
 tb/tb_select_position_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/select_position_gen.sv
// ---------------------------------------------------------------------------
// select_position_gen
//
// Writer side of the select-RAM window interface. Scans one 256-sample
// detector frame, finds up to three contiguous runs of samples at or above
// a per-frame threshold (runs shorter than MIN_WIDTH are dropped), and
// publishes the window bounds with a one-cycle position_gen_en pulse.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   frame_start             marks the accompanying valid sample as index 0
//   sample_valid            sample_in is valid this cycle
//   sample_in [DW]          unsigned detector sample
//   threshold [DW]          window threshold, captured with index 0
//   start_position_1..3     first index of windows 1..3 (0 when unfilled)
//   end_position_1..3       last index of windows 1..3 (0 when unfilled)
//   position_3_error_sig    fewer than three windows, or more than three
//   position_gen_en         one-cycle pulse: position outputs updated
//   windows_found [2]       accepted window count of the last frame
//   busy                    frame scan in progress
// ---------------------------------------------------------------------------
module select_position_gen #(
    parameter int DW        = 14,
    parameter int MIN_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_in,
    input  logic [DW-1:0] threshold,
    output logic [7:0]    start_position_1,
    output logic [7:0]    end_position_1,
    output logic [7:0]    start_position_2,
    output logic [7:0]    end_position_2,
    output logic [7:0]    start_position_3,
    output logic [7:0]    end_position_3,
    output logic          position_3_error_sig,
    output logic          position_gen_en,
    output logic [1:0]    windows_found,
    output logic          busy
);

    localparam logic [8:0] MIN_LEN = 9'(MIN_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN_LOW,
        S_SCAN_HIGH,
        S_DONE
    } state_t;

    // Control and working registers
    state_t          r_state;
    logic [DW-1:0]   r_thr;
    logic [7:0]      r_idx;
    logic [7:0]      r_cand;
    logic [1:0]      r_cnt;
    logic            r_ovf;
    logic            r_busy;
    logic [2:0][7:0] r_ws;
    logic [2:0][7:0] r_we;

    // Published outputs
    logic [2:0][7:0] r_os;
    logic [2:0][7:0] r_oe;
    logic            r_err;
    logic            r_pulse;
    logic [1:0]      r_wf;

    // Next-state values
    state_t          w_state_nxt;
    logic [DW-1:0]   w_thr_nxt;
    logic [7:0]      w_idx_nxt;
    logic [7:0]      w_cand_nxt;
    logic            w_busy_nxt;
    logic [1:0]      w_cnt_nxt;
    logic            w_ovf_nxt;
    logic [2:0][7:0] w_ws_nxt;
    logic [2:0][7:0] w_we_nxt;

    // Window close request from the scan logic
    logic            w_close;
    logic [7:0]      w_cs;
    logic [7:0]      w_ce;
    logic [8:0]      w_len;

    // A new frame may start from any state except the single DONE cycle;
    // starting while scanning abandons the old frame.
    logic            w_restart;
    logic            w_accept;
    logic [DW-1:0]   w_thr_eff;
    logic [7:0]      w_idx_eff;
    logic            w_in_high;
    logic            w_above;
    logic [1:0]      w_cnt_base;
    logic            w_ovf_base;
    logic [2:0][7:0] w_ws_base;
    logic [2:0][7:0] w_we_base;

    assign w_restart  = sample_valid && frame_start && (r_state != S_DONE);
    assign w_accept   = w_restart ||
                        (sample_valid && ((r_state == S_SCAN_LOW) || (r_state == S_SCAN_HIGH)));
    // The sample that starts a frame is compared against the live threshold
    // input, since the latched copy only becomes valid on the next cycle.
    assign w_thr_eff  = w_restart ? threshold : r_thr;
    assign w_idx_eff  = w_restart ? 8'd0 : r_idx;
    assign w_in_high  = !w_restart && (r_state == S_SCAN_HIGH);
    assign w_above    = (sample_in >= w_thr_eff);
    assign w_cnt_base = w_restart ? 2'd0 : r_cnt;
    assign w_ovf_base = w_restart ? 1'b0 : r_ovf;
    assign w_ws_base  = w_restart ? '0 : r_ws;
    assign w_we_base  = w_restart ? '0 : r_we;

    // 9-bit so a full 256-sample run does not wrap to zero
    assign w_len      = {1'b0, w_ce} - {1'b0, w_cs} + 9'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_thr_nxt   = r_thr;
        w_idx_nxt   = r_idx;
        w_cand_nxt  = r_cand;
        w_busy_nxt  = r_busy;
        w_close     = 1'b0;
        w_cs        = r_cand;
        w_ce        = 8'd0;

        case (r_state)
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                if (w_accept) begin
                    w_thr_nxt  = w_thr_eff;
                    w_idx_nxt  = w_idx_eff + 8'd1;
                    w_busy_nxt = 1'b1;
                    if (w_idx_eff == 8'd255) begin
                        // Last sample: any open run is closed here, and an
                        // above-threshold sample in LOW forms a 1-sample run.
                        w_state_nxt = S_DONE;
                        if (w_above) begin
                            w_close = 1'b1;
                            w_cs    = w_in_high ? r_cand : 8'd255;
                            w_ce    = 8'd255;
                        end else if (w_in_high) begin
                            w_close = 1'b1;
                            w_ce    = 8'd254;
                        end
                    end else if (!w_in_high && w_above) begin
                        w_cand_nxt  = w_idx_eff;
                        w_state_nxt = S_SCAN_HIGH;
                    end else if (w_in_high && !w_above) begin
                        w_close     = 1'b1;
                        w_ce        = w_idx_eff - 8'd1;
                        w_state_nxt = S_SCAN_LOW;
                    end else begin
                        w_state_nxt = w_in_high ? S_SCAN_HIGH : S_SCAN_LOW;
                    end
                end
            end
        endcase
    end

    // Window acceptance: drop short runs, fill slots in order, and flag
    // overflow once all three slots are taken.
    always_comb begin
        w_cnt_nxt = w_cnt_base;
        w_ovf_nxt = w_ovf_base;
        w_ws_nxt  = w_ws_base;
        w_we_nxt  = w_we_base;
        if (w_close && (w_len >= MIN_LEN)) begin
            if (w_cnt_base == 2'd3) begin
                w_ovf_nxt = 1'b1;
            end else begin
                case (w_cnt_base)
                    2'd0: begin
                        w_ws_nxt[0] = w_cs;
                        w_we_nxt[0] = w_ce;
                    end
                    2'd1: begin
                        w_ws_nxt[1] = w_cs;
                        w_we_nxt[1] = w_ce;
                    end
                    default: begin
                        w_ws_nxt[2] = w_cs;
                        w_we_nxt[2] = w_ce;
                    end
                endcase
                w_cnt_nxt = w_cnt_base + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_thr   <= '0;
            r_idx   <= '0;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_ws    <= '0;
            r_we    <= '0;
            r_os    <= '0;
            r_oe    <= '0;
            r_err   <= 1'b0;
            r_pulse <= 1'b0;
            r_wf    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_thr   <= w_thr_nxt;
            r_idx   <= w_idx_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            r_busy  <= w_busy_nxt;
            r_ws    <= w_ws_nxt;
            r_we    <= w_we_nxt;
            r_pulse <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_os  <= r_ws;
                r_oe  <= r_we;
                r_err <= (r_cnt != 2'd3) || r_ovf;
                r_wf  <= r_cnt;
            end
        end
    end

    assign start_position_1     = r_os[0];
    assign end_position_1       = r_oe[0];
    assign start_position_2     = r_os[1];
    assign end_position_2       = r_oe[1];
    assign start_position_3     = r_os[2];
    assign end_position_3       = r_oe[2];
    assign position_3_error_sig = r_err;
    assign position_gen_en      = r_pulse;
    assign windows_found        = r_wf;
    assign busy                 = r_busy;

endmodule

// File: tb/tb_select_position_gen.sv
// ---------------------------------------------------------------------------
// tb_select_position_gen
//
// Table of directed frames (window layouts with hand-derived results), abort
// and reset sequences, then randomized frames checked against a run-finding
// reference model.
// ---------------------------------------------------------------------------
module tb_select_position_gen;

    localparam int DW = 14;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic [DW-1:0] threshold = '0;
    logic [7:0]    start_position_1, end_position_1;
    logic [7:0]    start_position_2, end_position_2;
    logic [7:0]    start_position_3, end_position_3;
    logic          position_3_error_sig;
    logic          position_gen_en;
    logic [1:0]    windows_found;
    logic          busy;

    select_position_gen #(.DW(DW), .MIN_WIDTH(MW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .frame_start          (frame_start),
        .sample_valid         (sample_valid),
        .sample_in            (sample_in),
        .threshold            (threshold),
        .start_position_1     (start_position_1),
        .end_position_1       (end_position_1),
        .start_position_2     (start_position_2),
        .end_position_2       (end_position_2),
        .start_position_3     (start_position_3),
        .end_position_3       (end_position_3),
        .position_3_error_sig (position_3_error_sig),
        .position_gen_en      (position_gen_en),
        .windows_found        (windows_found),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_errors  = 0;
    int pulse_cnt = 0;

    always @(posedge clk) if (position_gen_en) pulse_cnt <= pulse_cnt + 1;

    logic [DW-1:0] frame_mem [256];

    typedef struct {
        int              thr;
        int              hi;
        int              lo;
        int              gap;
        logic [3:0][8:0] rs;
        logic [3:0][8:0] re;
        int              es [3];
        int              ee [3];
        int              err;
        int              wf;
    } vec_t;

    vec_t vecs [9];

    // Reference model results
    int m_s [3];
    int m_e [3];
    int m_err;
    int m_wf;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int thr, hi, lo, gap,
                                input int r0s, r0e, r1s, r1e, r2s, r2e, r3s, r3e,
                                input int s1, e1, s2, e2, s3, e3, err, wf);
        vec_t v;
        v.thr = thr; v.hi = hi; v.lo = lo; v.gap = gap;
        v.rs[0] = 9'(r0s); v.re[0] = 9'(r0e);
        v.rs[1] = 9'(r1s); v.re[1] = 9'(r1e);
        v.rs[2] = 9'(r2s); v.re[2] = 9'(r2e);
        v.rs[3] = 9'(r3s); v.re[3] = 9'(r3e);
        v.es[0] = s1; v.ee[0] = e1;
        v.es[1] = s2; v.ee[1] = e2;
        v.es[2] = s3; v.ee[2] = e3;
        v.err = err; v.wf = wf;
        return v;
    endfunction

    task automatic fill_from_vec(input int k);
        for (int i = 0; i < 256; i++) frame_mem[i] = DW'(vecs[k].lo);
        for (int r = 0; r < 4; r++) begin
            if (vecs[k].rs[r] != 9'h1FF) begin
                for (int j = int'(vecs[k].rs[r]); j <= int'(vecs[k].re[r]); j++)
                    frame_mem[j] = DW'(vecs[k].hi);
            end
        end
    endtask

    // Run-finding model: list every maximal above-threshold run that is long
    // enough; the first three are the slots, anything else is an error.
    task automatic model(input int thr);
        int total;
        int st;
        total = 0;
        st = -1;
        for (int k = 0; k < 3; k++) begin m_s[k] = 0; m_e[k] = 0; end
        for (int i = 0; i < 256; i++) begin
            int e;
            e = -1;
            if (int'(frame_mem[i]) >= thr) begin
                if (st < 0) st = i;
                if (i == 255) e = 255;
            end else if (st >= 0) begin
                e = i - 1;
            end
            if (e >= 0) begin
                if (e - st + 1 >= MW) begin
                    if (total < 3) begin m_s[total] = st; m_e[total] = e; end
                    total++;
                end
                st = -1;
            end
        end
        m_err = (total != 3) ? 1 : 0;
        m_wf  = (total > 3) ? 3 : total;
    endtask

    // Feed the first n samples of frame_mem; index 0 carries frame_start.
    task automatic drive_frame(input int thr, input int gap, input bit rnd, input int n);
        for (int i = 0; i < n; i++) begin
            int ng;
            ng = rnd ? int'($urandom_range(0, gap)) : gap;
            repeat (ng) begin
                sample_valid = 1'b0;
                frame_start  = 1'($urandom_range(0, 1));
                sample_in    = DW'($urandom);
                @(posedge clk); #1;
            end
            sample_valid = 1'b1;
            frame_start  = (i == 0);
            sample_in    = frame_mem[i];
            if (i == 0) threshold = DW'(thr);
            @(posedge clk); #1;
            sample_valid = 1'b0;
            frame_start  = 1'b0;
            if (i == 0) begin
                chk("busy_after_start", int'(busy), 1);
                threshold = DW'($urandom);
            end
        end
    endtask

    // Called #1 after the edge that accepted index 255.
    task automatic finish_frame(input string tag, input int s1, e1, s2, e2, s3, e3, err, wf);
        chk({tag, "_pulse_early"}, int'(position_gen_en), 0);
        chk({tag, "_busy_last"}, int'(busy), 1);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, int'(position_gen_en), 1);
        chk({tag, "_busy_done"}, int'(busy), 0);
        chk({tag, "_s1"}, int'(start_position_1), s1);
        chk({tag, "_e1"}, int'(end_position_1), e1);
        chk({tag, "_s2"}, int'(start_position_2), s2);
        chk({tag, "_e2"}, int'(end_position_2), e2);
        chk({tag, "_s3"}, int'(start_position_3), s3);
        chk({tag, "_e3"}, int'(end_position_3), e3);
        chk({tag, "_err"}, int'(position_3_error_sig), err);
        chk({tag, "_wf"}, int'(windows_found), wf);
        @(posedge clk); #1;
        chk({tag, "_pulse_one_cycle"}, int'(position_gen_en), 0);
        chk({tag, "_hold_e1"}, int'(end_position_1), e1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s1"}, int'(start_position_1), 0);
        chk({tag, "_e1"}, int'(end_position_1), 0);
        chk({tag, "_s2"}, int'(start_position_2), 0);
        chk({tag, "_e2"}, int'(end_position_2), 0);
        chk({tag, "_s3"}, int'(start_position_3), 0);
        chk({tag, "_e3"}, int'(end_position_3), 0);
        chk({tag, "_err"}, int'(position_3_error_sig), 0);
        chk({tag, "_en"}, int'(position_gen_en), 0);
        chk({tag, "_wf"}, int'(windows_found), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int frames_done;
        int pc0;
        frames_done = 0;

        //        thr   hi     lo   gap  runs (start,end) x4                           expected s1,e1,s2,e2,s3,e3,err,wf
        vecs[0] = mk(1000, 3000, 0,   0, 10, 29, 80, 99, 200, 219, -1, -1,           10, 29, 80, 99, 200, 219, 0, 3);
        vecs[1] = mk(1000, 3000, 0,   0, 10, 29, 80, 99, -1, -1, -1, -1,             10, 29, 80, 99, 0, 0, 1, 2);
        vecs[2] = mk(1000, 3000, 0,   0, 10, 29, 80, 99, 200, 219, 240, 249,         10, 29, 80, 99, 200, 219, 1, 3);
        vecs[3] = mk(1000, 3000, 0,   0, 5, 7, 10, 29, 80, 99, 200, 219,             10, 29, 80, 99, 200, 219, 0, 3);
        vecs[4] = mk(1000, 1000, 999, 0, 0, 9, 100, 119, 250, 255, -1, -1,           0, 9, 100, 119, 250, 255, 0, 3);
        vecs[5] = mk(1000, 1000, 999, 2, 0, 9, 100, 119, 250, 255, -1, -1,           0, 9, 100, 119, 250, 255, 0, 3);
        vecs[6] = mk(500, 16383, 0,   0, 50, 53, 60, 62, 70, 73, 252, 255,           50, 53, 70, 73, 252, 255, 0, 3);
        vecs[7] = mk(500, 16383, 0,   0, 0, 3, 251, 254, -1, -1, -1, -1,             0, 3, 251, 254, 0, 0, 1, 2);
        vecs[8] = mk(1000, 3000, 0,   1, 10, 29, 80, 99, 255, 255, -1, -1,           10, 29, 80, 99, 0, 0, 1, 2);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 9; k++) begin
            fill_from_vec(k);
            drive_frame(vecs[k].thr, vecs[k].gap, 1'b0, 256);
            finish_frame($sformatf("vec%0d", k), vecs[k].es[0], vecs[k].ee[0],
                         vecs[k].es[1], vecs[k].ee[1], vecs[k].es[2], vecs[k].ee[2],
                         vecs[k].err, vecs[k].wf);
            frames_done++;
        end
        chk("pulses_table", pulse_cnt, frames_done);

        // Abort: start a new frame while the previous one is at index 128
        pc0 = pulse_cnt;
        fill_from_vec(1);
        drive_frame(vecs[1].thr, 0, 1'b0, 128);
        chk("abort_no_pulse", pulse_cnt, pc0);
        fill_from_vec(0);
        drive_frame(vecs[0].thr, 0, 1'b0, 256);
        finish_frame("abort", 10, 29, 80, 99, 200, 219, 0, 3);
        frames_done++;
        chk("abort_one_pulse", pulse_cnt, pc0 + 1);

        // Reset at index 60 clears the published outputs and drops the frame
        pc0 = pulse_cnt;
        fill_from_vec(2);
        drive_frame(vecs[2].thr, 0, 1'b0, 60);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midreset");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midreset_no_pulse", pulse_cnt, pc0);
        fill_from_vec(4);
        drive_frame(vecs[4].thr, 0, 1'b0, 256);
        finish_frame("after_reset", 0, 9, 100, 119, 250, 255, 0, 3);
        frames_done++;

        // Random frames against the reference model
        for (int f = 0; f < 8; f++) begin
            int thr;
            bit lvl;
            thr = int'($urandom_range(1, 16383));
            lvl = 1'($urandom_range(0, 1));
            for (int i = 0; i < 256; i++) begin
                if ($urandom_range(0, 7) == 0) lvl = ~lvl;
                frame_mem[i] = lvl ? DW'($urandom_range(thr, 16383))
                                   : DW'($urandom_range(0, thr - 1));
            end
            model(thr);
            drive_frame(thr, 2, 1'b1, 256);
            finish_frame($sformatf("rnd%0d", f), m_s[0], m_e[0], m_s[1], m_e[1],
                         m_s[2], m_e[2], m_err, m_wf);
            frames_done++;
        end
        chk("pulses_total", pulse_cnt, frames_done);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
